dallanma_cozum_denetleyici: RTL and testbench
=============================================

// Module: dallanma_cozum_denetleyici
// PURPOSE
//  Sequences the branch predictor between fetch and execute.
//  - Queues every predicted branch issued by fetch, in order: PC plus predicted direction.
//  - Matches in-order resolutions from execute against the oldest queued entry.
//  - Drives the predictor's training/update port.
//  - On a direction mispredict, issues a fetch redirect and flushes the wrong-path entries.
//  - Keeps saturating branch and mispredict counters.
// PARAMETERS
//  DERINLIK  4   in-flight queue depth; power of 2, >=2
//  ADRES_W   32  PC/target width
//  SAYAC_W   16  performance counter width
// PORTS
//  i_saat               in   1        clock; all state on rising edge
//  i_reset              in   1        synchronous, active-high reset
//  i_kayit_gecerli      in   1        fetch presents a predicted branch
//  i_kayit_pc           in   ADRES_W  PC of that branch
//  i_kayit_ongoru       in   1        predicted direction (1 = taken)
//  o_kayit_hazir        out  1        queue accepts a record this cycle
//  i_cozum_gecerli      in   1        execute resolves the oldest branch
//  i_cozum_atladi       in   1        actual direction (1 = taken)
//  i_cozum_hedef        in   ADRES_W  actual taken target
//  o_guncelle_gecerli   out  1        predictor update strobe (1 cycle)
//  o_guncelle_pc        out  ADRES_W  PC to train
//  o_guncelle_atladi    out  1        outcome to train
//  o_yonlendir_gecerli  out  1        mispredict, redirect fetch (1 cycle)
//  o_yonlendir_pc       out  ADRES_W  correct next PC
//  o_bos                out  1        queue empty
//  o_hata               out  1        sticky: resolution arrived with queue empty
//  o_dallanma_sayisi    out  SAYAC_W  resolved branches, saturating
//  o_yanlis_sayisi      out  SAYAC_W  mispredicts, saturating
// BEHAVIOUR
//  Reset:
//  - Queue emptied, pointers 0, state CALIS.
//  - All o_* = 0 except o_kayit_hazir = 1 and o_bos = 1; counters 0; o_hata cleared.
//  - Reset mid-operation discards all in-flight entries and any pending update/redirect.
//  Push:
//  - Happens when i_kayit_gecerli & o_kayit_hazir.
//  - o_kayit_hazir = (state == CALIS) & (count < DERINLIK); no combinational dependence on i_cozum_*.
//  Pop:
//  - Happens when i_cozum_gecerli & state == CALIS & count > 0; head is compared.
//  - i_cozum_gecerli with count == 0: ignored, o_hata set next cycle; a same-cycle push is still accepted.
//  Push and pop in the same cycle (not full): both occur, count unchanged.
//  - Pointers wrap modulo DERINLIK; count is clog2(DERINLIK)+1 bits.
//  Update path, 1-cycle latency:
//  - A pop in cycle N gives o_guncelle_gecerli = 1 in N+1.
//  - o_guncelle_pc = head PC; o_guncelle_atladi = i_cozum_atladi.
//  - o_dallanma_sayisi increments (saturating) at the end of N.
//  Mispredict:
//  - Condition: head ongoru != i_cozum_atladi. Direction only; the target is not checked.
//  - In N+1: o_yonlendir_gecerli = 1.
//  - o_yonlendir_pc = i_cozum_atladi ? i_cozum_hedef : head PC + 4, truncated to ADRES_W.
//  - o_yanlis_sayisi increments (saturating) at the end of N.
//  FSM (2 states):
//  - CALIS --mispredict pop--> TEMIZLE.
//  - TEMIZLE lasts exactly 1 cycle (cycle N+1), then returns to CALIS.
//  - In TEMIZLE: o_kayit_hazir = 0; i_cozum_gecerli ignored (wrong path, no o_hata).
//  - At the end of TEMIZLE the whole queue is cleared, including any entry pushed in cycle N.
//  - Back in CALIS from N+2.
//  Counters hold at 2^SAYAC_W - 1; no wrap.
//  o_bos = (count == 0), registered view of the queue.
// STRUCTURE
//  Package dallanma_pkg:
//  - BUYRUK_BOYU = 4.
//  - State enum {CALIS, TEMIZLE}.
//  - Queue entry struct {pc[ADRES_W], ongoru}.
//  Sub-module ongoru_kuyrugu:
//  - Synchronous FIFO (push/pop/clear, count, empty/full).
//  - Same-cycle push+pop supported.
//  - Clear has priority over push.
//  Top level holds the FSM, compare logic, update/redirect registers and counters.
// TESTING
//  1. Reset for 2 cycles -> o_kayit_hazir=1, o_bos=1, all other outputs 0.
//  2. Push pc=0 ongoru=1; next cycle resolve atladi=1 hedef=0x40
//     -> N+1: guncelle_gecerli=1, pc=0, atladi=1; no redirect; dallanma=1, yanlis=0.
//  3. Push pc=8 ongoru=1; resolve atladi=0
//     -> N+1: yonlendir_gecerli=1, yonlendir_pc=0xC, o_kayit_hazir=0; N+2: o_bos=1, yanlis=1.
//  4. Push 4 entries (pc=0,4,8,12) with no resolution -> o_kayit_hazir=0;
//     5th push not taken; resolve -> head pc=0 popped; hazir=1 next cycle.
//  5. Resolve with queue empty -> o_hata=1 and stays 1; counters unchanged;
//     a push in the same cycle is accepted, o_bos=0.
//  6. Mispredict with 2 younger entries and a push in cycle N -> all flushed, o_bos=1 at N+2;
//     a resolution asserted in N+1 is ignored with no o_hata.
//     Then force yanlis to 16'hFFFF and mispredict -> counter holds at 16'hFFFF.

Source files
------------

// File: rtl/dallanma_pkg.sv
// Shared types for the branch resolution controller: FSM states, queue entry layout, instruction size.
package dallanma_pkg;
  localparam int BUYRUK_BOYU   = 4;
  localparam int KAYIT_ADRES_W = 32;

  typedef enum logic {
    CALIS   = 1'b0,
    TEMIZLE = 1'b1
  } durum_t;

  typedef struct packed {
    logic [KAYIT_ADRES_W-1:0] pc;
    logic                     ongoru;
  } kayit_t;
endpackage

// File: rtl/dallanma_cozum_denetleyici_ongoru_kuyrugu.sv
// In-order queue of predicted branches; clear wins over push, push and pop may share a cycle.
module ongoru_kuyrugu
  import dallanma_pkg::*;
#(
  parameter int  DERINLIK = 4,
  parameter type GIRIS_T  = kayit_t
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        temizle,
  input  logic                        yaz,
  input  logic                        oku,
  input  GIRIS_T                      yaz_veri,
  output GIRIS_T                      bas_veri,
  output logic [$clog2(DERINLIK):0]   sayi,
  output logic                        bos
);
  localparam int PW = $clog2(DERINLIK);
  localparam int SW = PW + 1;
  localparam logic [SW-1:0] DOLU_SAYI = SW'(DERINLIK);

  GIRIS_T          mem [DERINLIK];
  logic [PW-1:0]   yaz_ptr, oku_ptr;
  logic [SW-1:0]   sayi_q;
  logic            yaz_ok, oku_ok;

  assign yaz_ok   = yaz && (sayi_q != DOLU_SAYI);
  assign oku_ok   = oku && (sayi_q != '0);
  assign bas_veri = mem[oku_ptr];
  assign sayi     = sayi_q;
  assign bos      = (sayi_q == '0);

  always_ff @(posedge clk) begin
    if (rst || temizle) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      sayi_q  <= '0;
    end else begin
      if (yaz_ok) yaz_ptr <= yaz_ptr + 1'b1;
      if (oku_ok) oku_ptr <= oku_ptr + 1'b1;
      case ({yaz_ok, oku_ok})
        2'b10:   sayi_q <= sayi_q + 1'b1;
        2'b01:   sayi_q <= sayi_q - 1'b1;
        default: sayi_q <= sayi_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (yaz_ok) mem[yaz_ptr] <= yaz_veri;
  end
endmodule

// File: rtl/dallanma_cozum_denetleyici.sv
// Matches execute resolutions against queued predictions, trains the predictor and redirects fetch.
module dallanma_cozum_denetleyici
  import dallanma_pkg::*;
#(
  parameter int DERINLIK = 4,
  parameter int ADRES_W  = 32,
  parameter int SAYAC_W  = 16
) (
  input  logic               i_saat,
  input  logic               i_reset,
  input  logic               i_kayit_gecerli,
  input  logic [ADRES_W-1:0] i_kayit_pc,
  input  logic               i_kayit_ongoru,
  output logic               o_kayit_hazir,
  input  logic               i_cozum_gecerli,
  input  logic               i_cozum_atladi,
  input  logic [ADRES_W-1:0] i_cozum_hedef,
  output logic               o_guncelle_gecerli,
  output logic [ADRES_W-1:0] o_guncelle_pc,
  output logic               o_guncelle_atladi,
  output logic               o_yonlendir_gecerli,
  output logic [ADRES_W-1:0] o_yonlendir_pc,
  output logic               o_bos,
  output logic               o_hata,
  output logic [SAYAC_W-1:0] o_dallanma_sayisi,
  output logic [SAYAC_W-1:0] o_yanlis_sayisi
);
  localparam int SW = $clog2(DERINLIK) + 1;

  typedef struct packed {
    logic [ADRES_W-1:0] pc;
    logic               ongoru;
  } giris_t;

  durum_t             durum, durum_sonraki;
  giris_t             bas, yeni;
  logic [SW-1:0]      kuyruk_sayi;
  logic               kuyruk_bos, kayit_al, cozum_al, yanlis, hata_kosul;
  logic               guncelle_vld_p1, guncelle_atladi_p1, yonlendir_vld_p1, hata_q;
  logic [ADRES_W-1:0] guncelle_pc_p1, yonlendir_pc_p1;
  logic [SAYAC_W-1:0] dallanma_sayac, yanlis_sayac;

  function automatic logic [SAYAC_W-1:0] doygun_artir(input logic [SAYAC_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  function automatic logic [ADRES_W-1:0] dogru_sonraki_pc(input logic atladi,
                                                          input logic [ADRES_W-1:0] hedef,
                                                          input logic [ADRES_W-1:0] pc);
    return atladi ? hedef : pc + ADRES_W'(BUYRUK_BOYU);
  endfunction

  assign o_kayit_hazir = (durum == CALIS) && (kuyruk_sayi < SW'(DERINLIK));
  assign kayit_al      = i_kayit_gecerli && o_kayit_hazir;
  assign cozum_al      = i_cozum_gecerli && (durum == CALIS) && !kuyruk_bos;
  assign yanlis        = cozum_al && (bas.ongoru != i_cozum_atladi);
  assign hata_kosul    = i_cozum_gecerli && (durum == CALIS) && kuyruk_bos;
  assign yeni          = '{pc: i_kayit_pc, ongoru: i_kayit_ongoru};

  ongoru_kuyrugu #(
    .DERINLIK (DERINLIK),
    .GIRIS_T  (giris_t)
  ) u_kuyruk (
    .clk      (i_saat),
    .rst      (i_reset),
    .temizle  (durum == TEMIZLE),
    .yaz      (kayit_al),
    .oku      (cozum_al),
    .yaz_veri (yeni),
    .bas_veri (bas),
    .sayi     (kuyruk_sayi),
    .bos      (kuyruk_bos)
  );

  always_ff @(posedge i_saat) begin
    if (i_reset) durum <= CALIS;
    else         durum <= durum_sonraki;
  end

  always_comb begin
    durum_sonraki = durum;
    case (durum)
      CALIS:   if (yanlis) durum_sonraki = TEMIZLE;
      TEMIZLE: durum_sonraki = CALIS;
      default: durum_sonraki = CALIS;
    endcase
  end

  // stage p0 -> p1: resolution compare registered into update/redirect strobes and counters
  always_ff @(posedge i_saat) begin
    if (i_reset) begin
      guncelle_vld_p1    <= 1'b0;
      guncelle_pc_p1     <= '0;
      guncelle_atladi_p1 <= 1'b0;
      yonlendir_vld_p1   <= 1'b0;
      yonlendir_pc_p1    <= '0;
      hata_q             <= 1'b0;
      dallanma_sayac     <= '0;
      yanlis_sayac       <= '0;
    end else begin
      guncelle_vld_p1  <= cozum_al;
      yonlendir_vld_p1 <= yanlis;
      hata_q           <= hata_q | hata_kosul;
      if (cozum_al) begin
        guncelle_pc_p1     <= bas.pc;
        guncelle_atladi_p1 <= i_cozum_atladi;
        dallanma_sayac     <= doygun_artir(dallanma_sayac);
      end
      if (yanlis) begin
        yonlendir_pc_p1 <= dogru_sonraki_pc(i_cozum_atladi, i_cozum_hedef, bas.pc);
        yanlis_sayac    <= doygun_artir(yanlis_sayac);
      end
    end
  end

  assign o_guncelle_gecerli  = guncelle_vld_p1;
  assign o_guncelle_pc       = guncelle_pc_p1;
  assign o_guncelle_atladi   = guncelle_atladi_p1;
  assign o_yonlendir_gecerli = yonlendir_vld_p1;
  assign o_yonlendir_pc      = yonlendir_pc_p1;
  assign o_bos               = kuyruk_bos;
  assign o_hata              = hata_q;
  assign o_dallanma_sayisi   = dallanma_sayac;
  assign o_yanlis_sayisi     = yanlis_sayac;
endmodule

// File: tb/tb_dallanma_cozum_denetleyici.sv
// Directed scenarios; expected update/redirect strobes queued at issue and checked by a monitor.
module tb_dallanma_cozum_denetleyici;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        kgec = 1'b0, kong = 1'b0, cgec = 1'b0, catl = 1'b0;
  logic [31:0] kpc = '0, chedef = '0;
  logic        hazir, gvld, gatl, yvld, bos, hata;
  logic [31:0] gpc, ypc;
  logic [15:0] dal, yan;

  typedef struct {
    int          due;
    logic [31:0] pc;
    logic        atl;
  } beklenen_t;

  beklenen_t gq[$];
  beklenen_t yq[$];
  int n_cmp = 0, n_fail = 0, cyc = 0;

  dallanma_cozum_denetleyici dut (
    .i_saat(clk), .i_reset(rst),
    .i_kayit_gecerli(kgec), .i_kayit_pc(kpc), .i_kayit_ongoru(kong), .o_kayit_hazir(hazir),
    .i_cozum_gecerli(cgec), .i_cozum_atladi(catl), .i_cozum_hedef(chedef),
    .o_guncelle_gecerli(gvld), .o_guncelle_pc(gpc), .o_guncelle_atladi(gatl),
    .o_yonlendir_gecerli(yvld), .o_yonlendir_pc(ypc),
    .o_bos(bos), .o_hata(hata), .o_dallanma_sayisi(dal), .o_yanlis_sayisi(yan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    n_cmp++;
    if (gercek !== beklenen) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", ad, gercek, beklenen, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] pc, input logic ong);
    kgec = 1'b1; kpc = pc; kong = ong;
    step();
    kgec = 1'b0;
  endtask

  task automatic bekle_guncelle(input logic [31:0] pc, input logic atl);
    beklenen_t e;
    e.due = cyc + 1; e.pc = pc; e.atl = atl;
    gq.push_back(e);
  endtask

  task automatic bekle_yonlendir(input logic [31:0] pc);
    beklenen_t e;
    e.due = cyc + 1; e.pc = pc; e.atl = 1'b0;
    yq.push_back(e);
  endtask

  always @(negedge clk) begin
    beklenen_t e;
    if (gvld) begin
      if (gq.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL guncelle_beklenmeyen: got pc %h expected no strobe (cycle %0d)", gpc, cyc);
      end else begin
        e = gq.pop_front();
        chk("guncelle_zaman", cyc, e.due);
        chk("guncelle_pc", gpc, e.pc);
        chk("guncelle_atladi", {31'b0, gatl}, {31'b0, e.atl});
      end
    end else if (gq.size() > 0 && gq[0].due <= cyc) begin
      e = gq.pop_front();
      n_cmp++; n_fail++;
      $display("FAIL guncelle_eksik: got no strobe expected pc %h (cycle %0d)", e.pc, cyc);
    end
    if (yvld) begin
      if (yq.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL yonlendir_beklenmeyen: got pc %h expected no strobe (cycle %0d)", ypc, cyc);
      end else begin
        e = yq.pop_front();
        chk("yonlendir_zaman", cyc, e.due);
        chk("yonlendir_pc", ypc, e.pc);
      end
    end else if (yq.size() > 0 && yq[0].due <= cyc) begin
      e = yq.pop_front();
      n_cmp++; n_fail++;
      $display("FAIL yonlendir_eksik: got no strobe expected pc %h (cycle %0d)", e.pc, cyc);
    end
  end

  initial begin
    // reset state
    step(); step();
    chk("rst_hazir", {31'b0, hazir}, 32'd1);
    chk("rst_bos", {31'b0, bos}, 32'd1);
    chk("rst_gvld", {31'b0, gvld}, 32'd0);
    chk("rst_gpc", gpc, 32'd0);
    chk("rst_yvld", {31'b0, yvld}, 32'd0);
    chk("rst_ypc", ypc, 32'd0);
    chk("rst_hata", {31'b0, hata}, 32'd0);
    chk("rst_dal", {16'b0, dal}, 32'd0);
    chk("rst_yan", {16'b0, yan}, 32'd0);
    rst = 1'b0;
    step();

    // correct taken prediction
    push(32'h0, 1'b1);
    chk("t2_bos", {31'b0, bos}, 32'd0);
    cgec = 1'b1; catl = 1'b1; chedef = 32'h40;
    bekle_guncelle(32'h0, 1'b1);
    step(); cgec = 1'b0;
    chk("t2_dal", {16'b0, dal}, 32'd1);
    chk("t2_yan", {16'b0, yan}, 32'd0);
    chk("t2_bos_sonra", {31'b0, bos}, 32'd1);

    // mispredict: predicted taken, actually not taken
    push(32'h8, 1'b1);
    cgec = 1'b1; catl = 1'b0; chedef = 32'h99;
    bekle_guncelle(32'h8, 1'b0);
    bekle_yonlendir(32'hC);
    step(); cgec = 1'b0;
    chk("t3_hazir_temizle", {31'b0, hazir}, 32'd0);
    step();
    chk("t3_bos", {31'b0, bos}, 32'd1);
    chk("t3_yan", {16'b0, yan}, 32'd1);
    chk("t3_dal", {16'b0, dal}, 32'd2);
    chk("t3_hazir", {31'b0, hazir}, 32'd1);

    // fill to depth, overflow push refused, then drain
    push(32'h0, 1'b0); push(32'h4, 1'b0); push(32'h8, 1'b0); push(32'hC, 1'b0);
    chk("t4_hazir_dolu", {31'b0, hazir}, 32'd0);
    push(32'h10, 1'b0);
    chk("t4_hazir_hala", {31'b0, hazir}, 32'd0);
    cgec = 1'b1; catl = 1'b0; chedef = 32'h0;
    bekle_guncelle(32'h0, 1'b0);
    step();
    chk("t4_hazir_sonra", {31'b0, hazir}, 32'd1);
    chk("t4_dal", {16'b0, dal}, 32'd3);
    bekle_guncelle(32'h4, 1'b0); step();
    bekle_guncelle(32'h8, 1'b0); step();
    bekle_guncelle(32'hC, 1'b0); step();
    cgec = 1'b0;
    chk("t4_bos", {31'b0, bos}, 32'd1);
    chk("t4_dal_son", {16'b0, dal}, 32'd6);

    // resolution with empty queue plus same-cycle push
    cgec = 1'b1; catl = 1'b1; chedef = 32'h500;
    kgec = 1'b1; kpc = 32'h100; kong = 1'b1;
    step(); cgec = 1'b0; kgec = 1'b0;
    chk("t5_hata", {31'b0, hata}, 32'd1);
    chk("t5_bos", {31'b0, bos}, 32'd0);
    chk("t5_dal", {16'b0, dal}, 32'd6);
    chk("t5_yan", {16'b0, yan}, 32'd1);
    step();
    chk("t5_hata_yapiskan", {31'b0, hata}, 32'd1);
    cgec = 1'b1; catl = 1'b1; chedef = 32'h500;
    bekle_guncelle(32'h100, 1'b1);
    step(); cgec = 1'b0;
    chk("t5_dal_son", {16'b0, dal}, 32'd7);

    // reset mid-operation with a would-be mispredict pending
    push(32'h50, 1'b0); push(32'h54, 1'b0);
    rst = 1'b1; cgec = 1'b1; catl = 1'b1;
    step(); rst = 1'b0; cgec = 1'b0;
    chk("rr_bos", {31'b0, bos}, 32'd1);
    chk("rr_hata", {31'b0, hata}, 32'd0);
    chk("rr_dal", {16'b0, dal}, 32'd0);
    chk("rr_yan", {16'b0, yan}, 32'd0);
    step();

    // mispredict with younger entries and a push in the same cycle
    push(32'h200, 1'b1); push(32'h204, 1'b0); push(32'h208, 1'b1);
    cgec = 1'b1; catl = 1'b0; chedef = 32'h777;
    kgec = 1'b1; kpc = 32'h20C; kong = 1'b0;
    bekle_guncelle(32'h200, 1'b0);
    bekle_yonlendir(32'h204);
    step();
    chk("t6_hazir_temizle", {31'b0, hazir}, 32'd0);
    catl = 1'b1;
    step(); cgec = 1'b0; kgec = 1'b0;
    chk("t6_bos", {31'b0, bos}, 32'd1);
    chk("t6_hata", {31'b0, hata}, 32'd0);
    chk("t6_dal", {16'b0, dal}, 32'd1);
    chk("t6_yan", {16'b0, yan}, 32'd1);
    chk("t6_hazir", {31'b0, hazir}, 32'd1);

    // mispredict counter saturation
    force dut.yanlis_sayac = 16'hFFFF;
    step();
    release dut.yanlis_sayac;
    step();
    chk("sat_on", {16'b0, yan}, 32'h0000FFFF);
    push(32'h300, 1'b0);
    cgec = 1'b1; catl = 1'b1; chedef = 32'h3A0;
    bekle_guncelle(32'h300, 1'b1);
    bekle_yonlendir(32'h3A0);
    step(); cgec = 1'b0;
    step();
    chk("sat_yan", {16'b0, yan}, 32'h0000FFFF);
    chk("sat_dal", {16'b0, dal}, 32'd2);
    chk("sat_bos", {31'b0, bos}, 32'd1);

    step(); step();
    chk("kalan_guncelle", gq.size(), 32'd0);
    chk("kalan_yonlendir", yq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
